clinic_ticket_scheduler: RTL and testbench
==========================================

Name: clinic_ticket_scheduler

Overview:
- Front-end controller for the two-clinic ticket numerator.
- Four requesters share one ticket-queue resource: two patient kiosks (print a ticket for clinic 0 or 1) and two doctor call buttons (announce the next ticket for clinic 0 or 1).
- A round-robin arbiter grants one operation per clock. The block keeps both clinics' circular head/tail ticket pointers internally and answers every request with an ack or a nak pulse.
- It sits between the kiosk/button interface logic and the announce/print display drivers.

Parameters:
- C0_LO, 5, lowest ticket number of clinic 0
- C0_HI, 9, highest ticket number of clinic 0
- C1_LO, 10, lowest ticket number of clinic 1
- C1_HI, 14, highest ticket number of clinic 1
- Legal range for all four: 0..255, LO <= HI, HI-LO+1 <= 255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  4  request levels: [0] print c0, [1] print c1, [2] call c0, [3] call c1
- ack  out 4  one-cycle pulse; the matching request was performed
- nak  out 4  one-cycle pulse; the matching request was rejected (queue full on print, empty on call)
- print_num  out 8  ticket number issued by the last successful print
- print_valid  out 1  one-cycle pulse with each successful print
- ann0  out 8  ticket currently announced for clinic 0
- ann1  out 8  ticket currently announced for clinic 1
- ann_valid  out 2  bit i set once clinic i has announced at least one ticket since reset
- empty  out 2  clinic i queue empty
- full  out 2  clinic i queue full
- count0  out 8  tickets waiting in clinic 0
- count1  out 8  tickets waiting in clinic 1

Behaviour:
- Reset (async assert, released synchronously by the design): head_i = tail_i = Ci_LO, count_i = 0, empty = 2'b11, full = 2'b00, ack = nak = 0, print_num = 0, print_valid = 0, ann0 = ann1 = 0, ann_valid = 0, rr_ptr = 0. Pending work is discarded, and no ack/nak is emitted for requests outstanding at reset.
- Arbitration:
  - Each rising edge, among req bits that are high and not masked, grant the first one found searching upward from rr_ptr (mod 4).
  - Afterwards rr_ptr = grant+1 mod 4. No grant means no change.
- Masking: the granted bit is masked on the next cycle only, which absorbs the requester's one-cycle drop latency. A req still high after that is treated as a new request.
- Latency: ack/nak/print_valid and all state updates are registered at the edge that grants. The response is visible one cycle after req is sampled, and exactly one of ack/nak pulses per grant.
- Print on clinic i:
  - If count_i == Ci_HI-Ci_LO+1, pulse nak only; no state changes.
  - Otherwise print_num <= tail_i and print_valid pulses.
  - tail_i <= (tail_i == Ci_HI) ? Ci_LO : tail_i+1.
  - count_i <= count_i+1.
- Call on clinic i:
  - If count_i == 0, pulse nak; ann_i holds its value.
  - Otherwise ann_i <= head_i and ann_valid[i] <= 1.
  - head_i <= (head_i == Ci_HI) ? Ci_LO : head_i+1.
  - count_i <= count_i-1.
- Flags: empty[i] = (count_i == 0) and full[i] = (count_i == capacity_i), both derived from registered count. They reflect the post-grant state in the same cycle as ack.
- Single-op rule: one queue operation per cycle total, so insert/delete on the same clinic never collide. The losing requester waits, which bounds worst-case wait at 3 cycles when others keep requesting.
- Arithmetic is unsigned 8-bit, and pointer wrap uses compare-to-HI, never modulo.
- The tail wrap when HI == 255 must not overflow into ambiguity; it is covered by the explicit compare.
- print_num persists until the next successful print. ann0/ann1 persist until the next successful call or reset.
- No combinational path from req to any output.

Test Plan:
- Reset, then req=4'b0001 for 1 cycle -> next cycle ack=4'b0001, print_valid=1, print_num=5, count0=1, empty=2'b10.
- Six back-to-back prints on c0 (req[0] pulsed each time after the masked cycle) -> print_num 5,6,7,8,9, then the sixth gets nak[0]=1, full[0]=1, count0=5.
- Call c1 after reset (req=4'b1000) -> nak=4'b1000, ann1=0, ann_valid=2'b00. Then print c1 twice (10, 11) and call c1 -> ann1=10, ann_valid[1]=1, count1=1.
- Hold req=4'b1111 continuously from rr_ptr=0 -> grants in order 0,1,2,3,0..., each requester acked at most once per 4 cycles, no cycle with two ack/nak bits set.
- Wrap test on c1: print 5 and call 5 cycling twice -> tail/head wrap 14->10, printed sequence 10..14,10..14, and ann1 tracks it identically.
- Assert rst mid-sequence with count0=3 and req high -> outputs return to reset values immediately (asynchronously), no ack/nak that cycle, and the first print after release gives print_num=5.

Source files
------------

// File: rtl/clinic_ticket_scheduler.sv
// Round-robin front end for the two-clinic ticket numerator: arbitrates kiosk prints
// and doctor calls onto one shared queue operation per clock.
module clinic_ticket_scheduler #(
    parameter int unsigned C0_LO = 5,
    parameter int unsigned C0_HI = 9,
    parameter int unsigned C1_LO = 10,
    parameter int unsigned C1_HI = 14
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] ack,
    output logic [3:0] nak,
    output logic [7:0] print_num,
    output logic       print_valid,
    output logic [7:0] ann0,
    output logic [7:0] ann1,
    output logic [1:0] ann_valid,
    output logic [1:0] empty,
    output logic [1:0] full,
    output logic [7:0] count0,
    output logic [7:0] count1
);

    localparam logic [1:0][7:0] LO  = {8'(C1_LO), 8'(C0_LO)};
    localparam logic [1:0][7:0] HI  = {8'(C1_HI), 8'(C0_HI)};
    localparam logic [1:0][7:0] CAP = {8'(C1_HI - C1_LO + 1), 8'(C0_HI - C0_LO + 1)};

    logic            rst_meta;
    logic            rst_hold;
    logic [1:0][7:0] head;
    logic [1:0][7:0] tail;
    logic [1:0][7:0] count;
    logic [1:0][7:0] ann;
    logic [1:0]      rr_ptr;
    logic [3:0]      mask;
    logic [3:0]      masked;
    logic [1:0]      idx;
    logic [1:0]      grant;
    logic            grant_valid;
    logic            op_clinic;
    logic            op_call;

    // Reset asserts immediately but is released only after two clean clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_meta <= 1'b1;
            rst_hold <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            rst_hold <= rst_meta;
        end
    end

    always_comb begin
        masked      = req & ~mask;
        idx         = '0;
        grant       = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!grant_valid && masked[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

    assign op_clinic = grant[0];
    assign op_call   = grant[1];

    // Request bit order makes grant[0] the clinic and grant[1] the call/print selector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || rst_hold) begin
            head        <= LO;
            tail        <= LO;
            count       <= '0;
            ann         <= '0;
            ann_valid   <= '0;
            rr_ptr      <= '0;
            mask        <= '0;
            ack         <= '0;
            nak         <= '0;
            print_num   <= '0;
            print_valid <= 1'b0;
        end else begin
            ack         <= '0;
            nak         <= '0;
            print_valid <= 1'b0;
            mask        <= '0;
            if (grant_valid) begin
                mask   <= 4'b0001 << grant;
                rr_ptr <= grant + 2'd1;
                if (!op_call) begin
                    if (count[op_clinic] == CAP[op_clinic]) begin
                        nak[grant] <= 1'b1;
                    end else begin
                        ack[grant]       <= 1'b1;
                        print_num        <= tail[op_clinic];
                        print_valid      <= 1'b1;
                        tail[op_clinic]  <= (tail[op_clinic] == HI[op_clinic]) ?
                                            LO[op_clinic] : tail[op_clinic] + 8'd1;
                        count[op_clinic] <= count[op_clinic] + 8'd1;
                    end
                end else begin
                    if (count[op_clinic] == 8'd0) begin
                        nak[grant] <= 1'b1;
                    end else begin
                        ack[grant]           <= 1'b1;
                        ann[op_clinic]       <= head[op_clinic];
                        ann_valid[op_clinic] <= 1'b1;
                        head[op_clinic]      <= (head[op_clinic] == HI[op_clinic]) ?
                                                LO[op_clinic] : head[op_clinic] + 8'd1;
                        count[op_clinic]     <= count[op_clinic] - 8'd1;
                    end
                end
            end
        end
    end

    assign ann0   = ann[0];
    assign ann1   = ann[1];
    assign count0 = count[0];
    assign count1 = count[1];
    assign empty  = {count[1] == 8'd0, count[0] == 8'd0};
    assign full   = {count[1] == CAP[1], count[0] == CAP[0]};

endmodule

// File: tb/tb_clinic_ticket_scheduler.sv
// Directed bench for clinic_ticket_scheduler: a behavioural queue model pushes expected
// output snapshots into a scoreboard that is popped and compared after each clock edge.
module tb_clinic_ticket_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ack;
    logic [3:0] nak;
    logic [7:0] print_num;
    logic       print_valid;
    logic [7:0] ann0;
    logic [7:0] ann1;
    logic [1:0] ann_valid;
    logic [1:0] empty;
    logic [1:0] full;
    logic [7:0] count0;
    logic [7:0] count1;

    typedef struct {
        logic [3:0] ack;
        logic [3:0] nak;
        logic       pv;
        logic [7:0] pnum;
        logic [7:0] ann0;
        logic [7:0] ann1;
        logic [1:0] annv;
        logic [7:0] c0;
        logic [7:0] c1;
        logic [1:0] empty;
        logic [1:0] full;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int         lo[2] = '{5, 10};
    int         hi[2] = '{9, 14};
    int         m_head[2];
    int         m_tail[2];
    int         m_cnt[2];
    int         m_ann[2];
    logic [1:0] m_annv;
    int         m_pnum;

    clinic_ticket_scheduler #(
        .C0_LO(5), .C0_HI(9), .C1_LO(10), .C1_HI(14)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack), .nak(nak),
        .print_num(print_num), .print_valid(print_valid),
        .ann0(ann0), .ann1(ann1), .ann_valid(ann_valid),
        .empty(empty), .full(full), .count0(count0), .count1(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_head[c] = lo[c];
            m_tail[c] = lo[c];
            m_cnt[c]  = 0;
            m_ann[c]  = 0;
        end
        m_annv = 2'b00;
        m_pnum = 0;
    endtask

    task automatic push_snapshot(input logic [3:0] a, input logic [3:0] n, input logic pv);
        exp_t e;
        e.ack   = a;
        e.nak   = n;
        e.pv    = pv;
        e.pnum  = 8'(m_pnum);
        e.ann0  = 8'(m_ann[0]);
        e.ann1  = 8'(m_ann[1]);
        e.annv  = m_annv;
        e.c0    = 8'(m_cnt[0]);
        e.c1    = 8'(m_cnt[1]);
        e.empty = {m_cnt[1] == 0, m_cnt[0] == 0};
        e.full  = {m_cnt[1] == hi[1] - lo[1] + 1, m_cnt[0] == hi[0] - lo[0] + 1};
        sb.push_back(e);
    endtask

    // Bit 0/1 print on clinic 0/1, bit 2/3 call on clinic 0/1.
    task automatic model_op(input int b);
        int         c;
        logic [3:0] onehot;
        logic       pv;
        c      = b % 2;
        onehot = 4'b0001 << b;
        pv     = 1'b0;
        if (b < 2) begin
            if (m_cnt[c] == hi[c] - lo[c] + 1) begin
                push_snapshot(4'b0000, onehot, 1'b0);
                return;
            end
            m_pnum    = m_tail[c];
            pv        = 1'b1;
            m_tail[c] = (m_tail[c] == hi[c]) ? lo[c] : m_tail[c] + 1;
            m_cnt[c]  = m_cnt[c] + 1;
        end else begin
            if (m_cnt[c] == 0) begin
                push_snapshot(4'b0000, onehot, 1'b0);
                return;
            end
            m_ann[c]  = m_head[c];
            m_annv[c] = 1'b1;
            m_head[c] = (m_head[c] == hi[c]) ? lo[c] : m_head[c] + 1;
            m_cnt[c]  = m_cnt[c] - 1;
        end
        push_snapshot(onehot, 4'b0000, pv);
    endtask

    task automatic check_field(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_field({tag, ".scoreboard_empty"}, 8'd1, 8'd0);
            return;
        end
        e = sb.pop_front();
        check_field({tag, ".ack"}, 8'(ack), 8'(e.ack));
        check_field({tag, ".nak"}, 8'(nak), 8'(e.nak));
        check_field({tag, ".print_valid"}, 8'(print_valid), 8'(e.pv));
        check_field({tag, ".print_num"}, print_num, e.pnum);
        check_field({tag, ".ann0"}, ann0, e.ann0);
        check_field({tag, ".ann1"}, ann1, e.ann1);
        check_field({tag, ".ann_valid"}, 8'(ann_valid), 8'(e.annv));
        check_field({tag, ".count0"}, count0, e.c0);
        check_field({tag, ".count1"}, count1, e.c1);
        check_field({tag, ".empty"}, 8'(empty), 8'(e.empty));
        check_field({tag, ".full"}, 8'(full), 8'(e.full));
    endtask

    // One granted request followed by an idle cycle so the mask clears.
    task automatic apply_stimulus(input string tag, input int b);
        @(negedge clk);
        req = 4'b0001 << b;
        model_op(b);
        @(posedge clk);
        #1 check_output(tag);
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk);
        #1;
        push_snapshot(4'b0000, 4'b0000, 1'b0);
        check_output({tag, "_idle"});
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        push_snapshot(4'b0000, 4'b0000, 1'b0);
        check_output(tag);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        model_reset();
        $display("[TB] start");

        apply_reset("reset");

        for (int i = 0; i < 6; i++) apply_stimulus("print_c0", 0);

        apply_stimulus("call_c1_empty", 3);
        apply_stimulus("print_c1", 1);
        apply_stimulus("print_c1", 1);
        apply_stimulus("call_c1", 3);

        apply_reset("reset_wrap");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 5; i++) apply_stimulus("wrap_print_c1", 1);
            for (int i = 0; i < 5; i++) apply_stimulus("wrap_call_c1", 3);
        end

        apply_reset("reset_rr");
        @(negedge clk);
        req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            model_op(i % 4);
            @(posedge clk);
            #1 check_output("rr_all");
        end
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk);
        #1;
        push_snapshot(4'b0000, 4'b0000, 1'b0);
        check_output("rr_idle");

        apply_reset("reset_async");
        for (int i = 0; i < 3; i++) apply_stimulus("pre_rst_print", 0);
        @(negedge clk);
        req = 4'b0001;
        #2 rst = 1'b1;
        #1;
        model_reset();
        push_snapshot(4'b0000, 4'b0000, 1'b0);
        check_output("async_rst_now");
        @(posedge clk);
        #1;
        push_snapshot(4'b0000, 4'b0000, 1'b0);
        check_output("async_rst_edge");
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_snapshot(4'b0000, 4'b0000, 1'b0);
        check_output("after_release");
        apply_stimulus("first_print_after_rst", 0);
        check_field("first_print_num_const", print_num, 8'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
